// File: rtl/lif_pkg.sv
// Shared types and default widths for the LIF neuron and its spike-rate monitor.
package lif_pkg;

  localparam int unsigned WIN_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned VMEM_W  = 7;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage

// File: rtl/lif_rate_result_reg.sv
// Single-entry result buffer: valid/ready handshake, drop-when-full and sticky overrun.
module lif_rate_result_reg #(
  parameter int unsigned WIN_W  = lif_pkg::WIN_W,
  parameter int unsigned CNT_W  = lif_pkg::CNT_W,
  parameter int unsigned VMEM_W = lif_pkg::VMEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [VMEM_W-1:0] peak_in,
  input  logic [WIN_W-1:0]  isi_in,
  input  logic              res_ready,
  input  logic              clr_ovr,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic [VMEM_W-1:0] res_peak,
  output logic [WIN_W-1:0]  res_min_isi,
  output logic              overrun
);

  logic              valid_q;
  logic [CNT_W-1:0]  count_q;
  logic [VMEM_W-1:0] peak_q;
  logic [WIN_W-1:0]  isi_q;
  logic              ovr_q;
  logic              has_room;

  // The slot can take a new record if empty or being drained this cycle.
  assign has_room = !valid_q || res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      count_q <= '0;
      peak_q  <= '0;
      isi_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (load && has_room) begin
        valid_q <= 1'b1;
        count_q <= count_in;
        peak_q  <= peak_in;
        isi_q   <= isi_in;
      end else if (res_ready) begin
        valid_q <= 1'b0;
      end
      // Set wins over a simultaneous clear.
      if (load && !has_room) begin
        ovr_q <= 1'b1;
      end else if (clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign res_valid   = valid_q;
  assign res_count   = count_q;
  assign res_peak    = peak_q;
  assign res_min_isi = isi_q;
  assign overrun     = ovr_q;

endmodule

// File: rtl/lif_spike_rate_monitor.sv
// Windowed spike-count / peak-membrane monitor for the LIF neuron.
// Optional minimum inter-spike interval tracking under LIF_SPIKE_RATE_ISI_EN.
module lif_spike_rate_monitor
  import lif_pkg::state_e;
  import lif_pkg::IDLE;
  import lif_pkg::COUNT;
#(
  parameter int unsigned WIN_W  = lif_pkg::WIN_W,
  parameter int unsigned CNT_W  = lif_pkg::CNT_W,
  parameter int unsigned VMEM_W = lif_pkg::VMEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              spike_in,
  input  logic [VMEM_W-1:0] v_mem_in,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              res_ready,
  input  logic              clr_ovr,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic [VMEM_W-1:0] res_peak,
  output logic [WIN_W-1:0]  res_min_isi,
  output logic              busy,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  acc_count_q, acc_count_d, count_smp;
  logic [VMEM_W-1:0] acc_peak_q, acc_peak_d, peak_smp;
  logic [WIN_W-1:0]  min_isi_smp;
  logic              sample, done, reload, clear_acc, acc_en;

  assign sample = (state_q == COUNT) && enable;
  assign done   = sample && (win_cnt_q == WIN_W'(1));
  assign reload = enable && (win_len != '0);

  // Accumulator values including the current sample.
  assign count_smp = (acc_count_q == CNT_SAT) ? acc_count_q : acc_count_q + CNT_W'(spike_in);
  assign peak_smp  = (v_mem_in > acc_peak_q) ? v_mem_in : acc_peak_q;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    clear_acc = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (reload) begin
          state_d   = COUNT;
          win_cnt_d = win_len;
          clear_acc = 1'b1;
        end
      end
      COUNT: begin
        if (done) begin
          clear_acc = 1'b1;
          if (reload) begin
            win_cnt_d = win_len;
          end else begin
            state_d   = IDLE;
            win_cnt_d = '0;
          end
        end else if (sample) begin
          acc_en    = 1'b1;
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_count_d = acc_count_q;
    acc_peak_d  = acc_peak_q;
    if (clear_acc) begin
      acc_count_d = '0;
      acc_peak_d  = '0;
    end else if (acc_en) begin
      acc_count_d = count_smp;
      acc_peak_d  = peak_smp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      acc_count_q <= '0;
      acc_peak_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      acc_count_q <= acc_count_d;
      acc_peak_q  <= acc_peak_d;
    end
  end

`ifdef LIF_SPIKE_RATE_ISI_EN
  localparam logic [WIN_W-1:0] GAP_SAT = {WIN_W{1'b1}};

  logic [WIN_W-1:0] gap_q, min_isi_q, gap_inc;
  logic             seen_q;

  // gap_inc is the interval to a spike arriving in this sample.
  assign gap_inc     = (gap_q == GAP_SAT) ? gap_q : gap_q + WIN_W'(1);
  assign min_isi_smp = (spike_in && seen_q && (gap_inc < min_isi_q)) ? gap_inc : min_isi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= '0;
      seen_q    <= 1'b0;
      min_isi_q <= '0;
    end else if (clear_acc) begin
      gap_q     <= '0;
      seen_q    <= 1'b0;
      min_isi_q <= GAP_SAT;
    end else if (acc_en) begin
      gap_q     <= spike_in ? '0 : gap_inc;
      seen_q    <= seen_q | spike_in;
      min_isi_q <= min_isi_smp;
    end
  end
`else
  assign min_isi_smp = '0;
`endif

  lif_rate_result_reg #(
    .WIN_W (WIN_W),
    .CNT_W (CNT_W),
    .VMEM_W(VMEM_W)
  ) u_result (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (done),
    .count_in   (count_smp),
    .peak_in    (peak_smp),
    .isi_in     (min_isi_smp),
    .res_ready  (res_ready),
    .clr_ovr    (clr_ovr),
    .res_valid  (res_valid),
    .res_count  (res_count),
    .res_peak   (res_peak),
    .res_min_isi(res_min_isi),
    .overrun    (overrun)
  );

  assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_lif_spike_rate_monitor.sv
// Directed bench for lif_spike_rate_monitor; ISI expectations follow LIF_SPIKE_RATE_ISI_EN.
module tb_lif_spike_rate_monitor;

`ifdef LIF_SPIKE_RATE_ISI_EN
  localparam bit ISI = 1'b1;
`else
  localparam bit ISI = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       spike_in;
  logic [6:0] v_mem_in;
  logic [7:0] win_len;
  logic       res_ready;
  logic       clr_ovr;

  logic       res_valid, busy, overrun;
  logic [7:0] res_count, res_min_isi;
  logic [6:0] res_peak;

  logic       s_valid, s_busy, s_overrun;
  logic [3:0] s_count;
  logic [7:0] s_min_isi;
  logic [6:0] s_peak;

  int checks = 0;
  int errors = 0;

  lif_spike_rate_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .v_mem_in(v_mem_in), .win_len(win_len), .res_ready(res_ready), .clr_ovr(clr_ovr),
    .res_valid(res_valid), .res_count(res_count), .res_peak(res_peak),
    .res_min_isi(res_min_isi), .busy(busy), .overrun(overrun)
  );

  lif_spike_rate_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .v_mem_in(v_mem_in), .win_len(win_len), .res_ready(res_ready), .clr_ovr(clr_ovr),
    .res_valid(s_valid), .res_count(s_count), .res_peak(s_peak),
    .res_min_isi(s_min_isi), .busy(s_busy), .overrun(s_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; spike_in = 1'b0; v_mem_in = 7'd0;
    win_len = 8'd0; res_ready = 1'b0; clr_ovr = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(res_count), 32'd0);
    chk("rst_peak", 32'(res_peak), 32'd0);
    chk("rst_isi", 32'(res_min_isi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // win_len=4, spikes 1,0,1,1 / vmem 10,40,25,3
    enable = 1'b1; win_len = 8'd4; res_ready = 1'b1;
    cyc(1);
    chk("w4_busy_start", 32'(busy), 32'd1);
    spike_in = 1'b1; v_mem_in = 7'd10; cyc(1);
    spike_in = 1'b0; v_mem_in = 7'd40; cyc(1);
    spike_in = 1'b1; v_mem_in = 7'd25; cyc(1);
    chk("w4_valid_early", 32'(res_valid), 32'd0);
    spike_in = 1'b1; v_mem_in = 7'd3; cyc(1);
    chk("w4_valid", 32'(res_valid), 32'd1);
    chk("w4_count", 32'(res_count), 32'd3);
    chk("w4_peak", 32'(res_peak), 32'd40);
    chk("w4_isi", 32'(res_min_isi), ISI ? 32'd1 : 32'd0);
    chk("w4_busy_b2b", 32'(busy), 32'd1);
    // Second window back-to-back: 4 quiet samples at vmem 5
    spike_in = 1'b0; v_mem_in = 7'd5; cyc(1);
    chk("w4_accepted", 32'(res_valid), 32'd0);
    cyc(2);
    win_len = 8'd0; cyc(1);
    chk("w4b_valid", 32'(res_valid), 32'd1);
    chk("w4b_count", 32'(res_count), 32'd0);
    chk("w4b_peak", 32'(res_peak), 32'd5);
    chk("w4b_isi", 32'(res_min_isi), ISI ? 32'd255 : 32'd0);
    chk("w4b_idle", 32'(busy), 32'd0);

    // Enable toggling 1,0,1,0,1,0,1 with spikes throughout
    enable = 1'b0; win_len = 8'd4; spike_in = 1'b1; v_mem_in = 7'd7; cyc(1);
    chk("tg_drain", 32'(res_valid), 32'd0);
    enable = 1'b1; cyc(1);
    win_len = 8'd0;
    for (int i = 0; i < 6; i++) begin
      enable = (i % 2 == 0);
      cyc(1);
    end
    chk("tg_valid_early", 32'(res_valid), 32'd0);
    enable = 1'b1; cyc(1);
    chk("tg_valid", 32'(res_valid), 32'd1);
    chk("tg_count", 32'(res_count), 32'd4);
    chk("tg_peak", 32'(res_peak), 32'd7);
    chk("tg_isi", 32'(res_min_isi), ISI ? 32'd1 : 32'd0);

    // Overrun with res_ready=0, win_len=2
    enable = 1'b0; cyc(1);
    chk("ov_drain", 32'(res_valid), 32'd0);
    res_ready = 1'b0; win_len = 8'd2; enable = 1'b1; spike_in = 1'b1; v_mem_in = 7'd20;
    cyc(3);
    chk("ov_first_valid", 32'(res_valid), 32'd1);
    chk("ov_first_count", 32'(res_count), 32'd2);
    chk("ov_flag_clear", 32'(overrun), 32'd0);
    win_len = 8'd0; spike_in = 1'b0; v_mem_in = 7'd30; cyc(2);
    chk("ov_flag_set", 32'(overrun), 32'd1);
    chk("ov_valid_held", 32'(res_valid), 32'd1);
    chk("ov_count_held", 32'(res_count), 32'd2);
    chk("ov_peak_held", 32'(res_peak), 32'd20);
    chk("ov_isi_held", 32'(res_min_isi), ISI ? 32'd1 : 32'd0);
    enable = 1'b0; clr_ovr = 1'b1; cyc(1);
    chk("ov_cleared", 32'(overrun), 32'd0);
    chk("ov_valid_after_clr", 32'(res_valid), 32'd1);
    clr_ovr = 1'b0; res_ready = 1'b1; cyc(1);
    chk("ov_accepted", 32'(res_valid), 32'd0);

    // Reset in the middle of a win_len=5 window after 2 spikes
    win_len = 8'd5; enable = 1'b1; spike_in = 1'b1; v_mem_in = 7'd9; cyc(3);
    chk("mr_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_count0", 32'(res_count), 32'd0);
    chk("mr_peak0", 32'(res_peak), 32'd0);
    chk("mr_valid0", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1);
    win_len = 8'd0;
    cyc(4);
    chk("mr_no_stale_valid", 32'(res_valid), 32'd0);
    cyc(1);
    chk("mr_new_valid", 32'(res_valid), 32'd1);
    chk("mr_new_count", 32'(res_count), 32'd5);
    chk("mr_new_peak", 32'(res_peak), 32'd9);

    // Saturation: win_len=255, spike every sample
    enable = 1'b0; cyc(1);
    win_len = 8'd255; enable = 1'b1; spike_in = 1'b1; v_mem_in = 7'd50; cyc(1);
    win_len = 8'd0;
    cyc(254);
    chk("sat_valid_early", 32'(res_valid), 32'd0);
    cyc(1);
    chk("sat_valid", 32'(res_valid), 32'd1);
    chk("sat_count8", 32'(res_count), 32'd255);
    chk("sat_count4_valid", 32'(s_valid), 32'd1);
    chk("sat_count4", 32'(s_count), 32'd15);
    chk("sat_peak4", 32'(s_peak), 32'd50);

    // ISI: win_len=10, spikes at samples 1,4,6; then one spike only
    enable = 1'b0; spike_in = 1'b0; cyc(1);
    win_len = 8'd10; enable = 1'b1; cyc(1);
    for (int i = 1; i <= 10; i++) begin
      spike_in = (i == 1 || i == 4 || i == 6);
      v_mem_in = 7'(i);
      cyc(1);
    end
    chk("isi_valid", 32'(res_valid), 32'd1);
    chk("isi_count", 32'(res_count), 32'd3);
    chk("isi_peak", 32'(res_peak), 32'd10);
    chk("isi_min", 32'(res_min_isi), ISI ? 32'd2 : 32'd0);
    win_len = 8'd0;
    for (int i = 1; i <= 10; i++) begin
      spike_in = (i == 3);
      v_mem_in = 7'd0;
      cyc(1);
    end
    chk("isi1_valid", 32'(res_valid), 32'd1);
    chk("isi1_count", 32'(res_count), 32'd1);
    chk("isi1_min", 32'(res_min_isi), ISI ? 32'd255 : 32'd0);
    chk("isi1_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
